// File: rtl/pedge_event_queue.sv
// rtl/pedge_event_queue.sv - latches edge pulses as pending events and queues {index, timestamp} records
module pedge_event_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TS_W  = 16,
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pedge,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IW-1:0]    ev_idx,
  output logic [TS_W-1:0]  ev_ts,
  output logic [WIDTH-1:0] pending,
  output logic             overflow,
  input  logic             ovf_clr
);

  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  stamp    [WIDTH];
  logic [IW-1:0]    mem_idx  [DEPTH];
  logic [TS_W-1:0]  mem_ts   [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             gvalid;
  logic [IW-1:0]    gidx;
  logic [WIDTH-1:0] grant;
  logic             coalesce;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = ev_valid & ev_ready;

  // Lowest-index pending bit wins; nothing is granted while the FIFO is full,
  // even if a pop is happening this cycle.
  always_comb begin
    gidx  = '0;
    grant = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) gidx = IW'(i);
    end
    gvalid = (|pending) && !full;
    if (gvalid) grant[gidx] = 1'b1;
  end

  // A pulse on a bit that is pending and not being granted merges into the old event.
  assign coalesce = |(pedge & pending & ~grant);

  // Free-running timestamp counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + 1'b1;
  end

  // Pending vector: granted bit leaves, new pulses enter (a pulse on the granted bit re-arms it).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~grant) | pedge;
  end

  // Per-bit stamps: a fresh event takes the current ts; a coalesced pulse keeps the old stamp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) stamp[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pedge[i] && (!pending[i] || grant[i])) stamp[i] <= ts;
      end
    end
  end

  // Sticky overflow; a coalesce in the same cycle as ovf_clr keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           overflow <= 1'b0;
    else if (coalesce) overflow <= 1'b1;
    else if (ovf_clr)  overflow <= 1'b0;
  end

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (gvalid) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head outputs.
  always_ff @(posedge clk) begin
    if (gvalid) begin
      mem_idx[wptr[AW-1:0]] <= gidx;
      mem_ts[wptr[AW-1:0]]  <= stamp[gidx];
    end
  end

  // Head outputs are forced to zero when empty so reset presents clean zeros.
  always_comb begin
    ev_valid = !empty;
    ev_idx   = ev_valid ? mem_idx[rptr[AW-1:0]] : '0;
    ev_ts    = ev_valid ? mem_ts[rptr[AW-1:0]]  : '0;
  end

endmodule

// File: tb/tb_pedge_event_queue.sv
// tb/tb_pedge_event_queue.sv - scoreboard bench for pedge_event_queue
module tb_pedge_event_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pedge = '0;
  logic        ev_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        ev_valid;
  logic [2:0]  ev_idx;
  logic [15:0] ev_ts;
  logic [7:0]  pending;
  logic        overflow;

  logic [7:0]  pedge4 = '0;
  logic        ready4 = 1'b0;
  logic        valid4;
  logic [2:0]  idx4;
  logic [3:0]  ts4;
  logic [7:0]  pending4;
  logic        overflow4;

  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] tsm;
  logic [18:0] sb [$];
  logic [18:0] exp_rec;

  pedge_event_queue #(.WIDTH(8), .DEPTH(4), .TS_W(16)) dut (
    .clk(clk), .rst(rst), .pedge(pedge), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_idx(ev_idx), .ev_ts(ev_ts), .pending(pending), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  pedge_event_queue #(.WIDTH(8), .DEPTH(4), .TS_W(4)) dut4 (
    .clk(clk), .rst(rst), .pedge(pedge4), .ev_valid(valid4), .ev_ready(ready4),
    .ev_idx(idx4), .ev_ts(ts4), .pending(pending4), .overflow(overflow4), .ovf_clr(1'b0)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: value of the DUT timestamp during the current cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) tsm <= '0;
    else     tsm <= tsm + 16'd1;
  end

  // Scoreboard monitor: every accepted record must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_record got idx=%0d ts=%0d required=no record", ev_idx, ev_ts);
      end else begin
        exp_rec = sb.pop_front();
        if ({ev_idx, ev_ts} !== exp_rec)
          $display("FAIL record got idx=%0d ts=%0d required idx=%0d ts=%0d",
                   ev_idx, ev_ts, exp_rec[18:16], exp_rec[15:0]);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int idx, input logic [15:0] t);
    sb.push_back({3'(idx), t});
  endtask

  task automatic drain(input string name);
    int k = 0;
    ev_ready = 1'b1;
    while ((sb.size() != 0 || ev_valid) && k < 40) begin
      tick();
      k++;
    end
    n_checks++;
    if (sb.size() != 0 || ev_valid !== 1'b0)
      $display("FAIL %s_drain got left=%0d ev_valid=%b required left=0 ev_valid=0", name, sb.size(), ev_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({ev_valid, ev_idx, ev_ts, pending, overflow} !== '0)
      $display("FAIL reset_outputs got v=%b i=%0d t=%0d p=%h o=%b required all 0", ev_valid, ev_idx, ev_ts, pending, overflow);
    else n_pass++;
    n_checks++;
    if ({valid4, idx4, ts4, pending4, overflow4} !== '0)
      $display("FAIL reset_outputs4 got v=%b p=%h required all 0", valid4, pending4);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_pair();
    ev_ready = 1'b1;
    pedge = 8'b1001_0000;
    push_exp(4, tsm);
    push_exp(7, tsm);
    tick();
    pedge = '0;
    n_checks++;
    if (ev_valid !== 1'b0 || pending !== 8'h90)
      $display("FAIL pair_latency got v=%b p=%h required v=0 p=90", ev_valid, pending);
    else n_pass++;
    tick();
    n_checks++;
    if (ev_valid !== 1'b1 || ev_idx !== 3'd4)
      $display("FAIL pair_first got v=%b idx=%0d required v=1 idx=4", ev_valid, ev_idx);
    else n_pass++;
    drain("pair");
  endtask

  task automatic test_fill();
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pedge = 8'(1 << i);
      push_exp(i, tsm);
      tick();
    end
    pedge = '0;
    repeat (2) tick();
    n_checks++;
    if (pending !== 8'h30 || overflow !== 1'b0)
      $display("FAIL fill_pending got p=%h o=%b required p=30 o=0", pending, overflow);
    else n_pass++;
    n_checks++;
    if (ev_valid !== 1'b1 || ev_idx !== 3'd0)
      $display("FAIL fill_head got v=%b idx=%0d required v=1 idx=0", ev_valid, ev_idx);
    else n_pass++;
    drain("fill");
    n_checks++;
    if (pending !== 8'h00)
      $display("FAIL fill_after got p=%h required 00", pending);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int bits [5] = '{0, 1, 3, 5, 2};
    ev_ready = 1'b0;
    foreach (bits[i]) begin
      pedge = 8'(1 << bits[i]);
      push_exp(bits[i], tsm);
      tick();
    end
    pedge = '0;
    repeat (2) tick();
    n_checks++;
    if (pending !== 8'h04 || overflow !== 1'b0)
      $display("FAIL ovf_pre got p=%h o=%b required p=04 o=0", pending, overflow);
    else n_pass++;
    pedge = 8'h04;
    tick();
    pedge = '0;
    n_checks++;
    if (overflow !== 1'b1 || pending !== 8'h04)
      $display("FAIL ovf_set got o=%b p=%h required o=1 p=04", overflow, pending);
    else n_pass++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0)
      $display("FAIL ovf_clear got %b required 0", overflow);
    else n_pass++;
    ovf_clr = 1'b1;
    pedge = 8'h04;
    tick();
    ovf_clr = 1'b0;
    pedge = '0;
    n_checks++;
    if (overflow !== 1'b1)
      $display("FAIL ovf_set_wins got %b required 1", overflow);
    else n_pass++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    drain("ovf");
  endtask

  task automatic test_regrant();
    ev_ready = 1'b1;
    pedge = 8'h08;
    push_exp(3, tsm);
    tick();
    push_exp(3, tsm);
    tick();
    pedge = '0;
    drain("regrant");
    n_checks++;
    if (overflow !== 1'b0)
      $display("FAIL regrant_ovf got %b required 0", overflow);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int k = 0;
    ready4 = 1'b1;
    while (tsm[3:0] != 4'h0 && k < 20) begin
      tick();
      k++;
    end
    pedge4 = 8'h42;
    tick();
    pedge4 = '0;
    tick();
    n_checks++;
    if (valid4 !== 1'b1 || idx4 !== 3'd1 || ts4 !== 4'h0)
      $display("FAIL wrap_first got v=%b idx=%0d ts=%0d required v=1 idx=1 ts=0", valid4, idx4, ts4);
    else n_pass++;
    tick();
    n_checks++;
    if (valid4 !== 1'b1 || idx4 !== 3'd6 || ts4 !== 4'h0)
      $display("FAIL wrap_second got v=%b idx=%0d ts=%0d required v=1 idx=6 ts=0", valid4, idx4, ts4);
    else n_pass++;
    tick();
    n_checks++;
    if (valid4 !== 1'b0 || pending4 !== 8'h00 || overflow4 !== 1'b0)
      $display("FAIL wrap_end got v=%b p=%h o=%b required v=0 p=00 o=0", valid4, pending4, overflow4);
    else n_pass++;
    ready4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    ev_ready = 1'b0;
    pedge = 8'h01;
    tick();
    pedge = 8'h02;
    tick();
    pedge = 8'h20;
    tick();
    pedge = '0;
    n_checks++;
    if (ev_valid !== 1'b1 || pending === 8'h00)
      $display("FAIL mid_pre got v=%b p=%h required v=1 p!=00", ev_valid, pending);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ev_valid, ev_idx, ev_ts, pending, overflow} !== '0)
      $display("FAIL mid_async got v=%b i=%0d t=%0d p=%h o=%b required all 0", ev_valid, ev_idx, ev_ts, pending, overflow);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    pedge = 8'h04;
    push_exp(2, 16'd0);
    tick();
    pedge = '0;
    drain("mid");
    repeat (3) tick();
    n_checks++;
    if (ev_valid !== 1'b0)
      $display("FAIL mid_stale got v=%b required 0", ev_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pair();
    test_fill();
    test_overflow();
    test_regrant();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
